// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Per-transfer ack watchdog: counts unacknowledged strobe cycles and emits a
// registered one-cycle expire pulse when the limit is reached.
module wb_arb_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam bit              WD_EN = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] ONE   = TO_W'(1);

  logic [TO_W-1:0] cnt_r;
  logic            err_r;
  logic            hit_s;

  // The limit is hit on the last unacknowledged cycle; the error shows up one cycle later.
  assign hit_s = WD_EN && run && !clear && (cnt_r == LIMIT);

  // Counter and error-pulse register; the counter is zeroed at expiry so it never wraps.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r <= {TO_W{1'b0}};
      err_r <= 1'b0;
    end else begin
      err_r <= hit_s;
      if (clear || hit_s || !WD_EN) begin
        cnt_r <= {TO_W{1'b0}};
      end else if (run) begin
        cnt_r <= cnt_r + ONE;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign expire = err_r;

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter with cycle-level ownership and an
// ack watchdog that terminates transfers to hung slaves.
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int ADR_W   = 32,
  parameter int DAT_W   = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  input  logic [3:0]       m0_sel_i,
  input  logic             m0_we_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  output logic [DAT_W-1:0] m0_dat_o,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  input  logic [3:0]       m1_sel_i,
  input  logic             m1_we_i,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  output logic [DAT_W-1:0] m1_dat_o,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [DAT_W-1:0] s_dat_o,
  output logic [3:0]       s_sel_o,
  output logic             s_we_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  input  logic [DAT_W-1:0] s_dat_i,
  input  logic             s_ack_i,
  output logic [1:0]       gnt_o,
  output logic             timeout_irq_o
);

  arb_state_e state_r, state_nxt_s;
  logic       last_r, last_nxt_s;
  logic       err_s;
  logic       wd_run_s, wd_clear_s;

  // Round-robin next-owner selection; a dropping owner hands straight to a waiting peer.
  always_comb begin
    state_nxt_s = state_r;
    last_nxt_s  = last_r;
    case (state_r)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_nxt_s = (last_r == OWNER_M1) ? ST_OWN0 : ST_OWN1;
        end else if (m0_cyc_i) begin
          state_nxt_s = ST_OWN0;
        end else if (m1_cyc_i) begin
          state_nxt_s = ST_OWN1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_OWN0: begin
        if (m0_cyc_i) begin
          state_nxt_s = ST_OWN0;
        end else begin
          last_nxt_s  = OWNER_M0;
          state_nxt_s = m1_cyc_i ? ST_OWN1 : ST_IDLE;
        end
      end
      ST_OWN1: begin
        if (m1_cyc_i) begin
          state_nxt_s = ST_OWN1;
        end else begin
          last_nxt_s  = OWNER_M1;
          state_nxt_s = m0_cyc_i ? ST_OWN0 : ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        last_nxt_s  = last_r;
      end
    endcase
  end

  // Ownership state and last-owner history; m0 wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      last_r  <= OWNER_M1;
    end else begin
      state_r <= state_nxt_s;
      last_r  <= last_nxt_s;
    end
  end

  // Slave-side mux and response routing; an error cycle suppresses stb and ack.
  always_comb begin
    s_adr_o  = {ADR_W{1'b0}};
    s_dat_o  = {DAT_W{1'b0}};
    s_sel_o  = 4'b0000;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    gnt_o    = GNT_NONE;
    case (state_r)
      ST_OWN0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i & ~err_s;
        m0_ack_o = s_ack_i & ~err_s;
        m0_err_o = err_s;
        gnt_o    = GNT_M0;
      end
      ST_OWN1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i & ~err_s;
        m1_ack_o = s_ack_i & ~err_s;
        m1_err_o = err_s;
        gnt_o    = GNT_M1;
      end
      default: begin
        gnt_o = GNT_NONE;
      end
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign wd_run_s   = s_stb_o & ~s_ack_i;
  assign wd_clear_s = (state_nxt_s != state_r) | ~s_stb_o | s_ack_i;

  wb_arb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .run    (wd_run_s),
    .clear  (wd_clear_s),
    .expire (err_s)
  );

  assign timeout_irq_o = err_s;

endmodule
